// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between core load/store path and host burst port
// Optional feature: define ARB_STATS_EN to add the saturating stall_cnt output.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int BURST_W  = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [AW-1:0]      core_addr,
    input  logic [DW-1:0]      core_wdata,
    output logic [DW-1:0]      core_rdata,
    output logic               core_stall,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [AW-1:0]      host_addr,
    input  logic [BURST_W-1:0] host_len,
    input  logic [DW-1:0]      host_wdata,
    output logic               host_ack,
    output logic [DW-1:0]      host_rdata,
    output logic               host_busy,
`ifdef ARB_STATS_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               mem_wr_en,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOST = 1'b1;

    localparam int             WW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0]  WAIT_LAST = WW'(MAX_WAIT - 1);

    logic [0:0]         state;
    logic [WW-1:0]      wait_cnt;
    logic [BURST_W-1:0] beat_cnt;
    logic [AW-1:0]      addr_q;
    logic               we_q;

    always_comb begin
        host_busy  = (state == ST_HOST);
        host_ack   = host_busy;
        core_stall = host_busy & core_req;
        host_rdata = mem_rdata;
        core_rdata = mem_rdata;
        if (host_busy) begin
            mem_addr  = addr_q;
            mem_wr_en = we_q;
            mem_wdata = host_wdata;
        end else begin
            // Gate with reset so a core store cannot leak through while reset is held.
            mem_addr  = core_addr;
            mem_wr_en = core_req & core_we & reset;
            mem_wdata = core_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            beat_cnt <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_req) begin
                        // Core wins ties until the host has waited MAX_WAIT core-served cycles.
                        if (!core_req || wait_cnt == WAIT_LAST) begin
                            state    <= ST_HOST;
                            addr_q   <= host_addr;
                            beat_cnt <= host_len;
                            we_q     <= host_we;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_HOST: begin
                    addr_q <= addr_q + 1'b1;
                    if (beat_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (core_stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural memory reference
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       core_stall;
    logic       host_req, host_we;
    logic [7:0] host_addr;
    logic [3:0] host_len;
    logic [7:0] host_wdata, host_rdata;
    logic       host_ack, host_busy;
    logic       mem_wr_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;

    dmem_arbiter #(.AW(8), .DW(8), .BURST_W(4), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata), .host_busy(host_busy),
`ifdef ARB_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_len = 0; host_wdata = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        core_req = 1; core_we = 1; core_addr = 8'h44; core_wdata = 8'h99;
        host_req = 1; host_we = 1;
        @(negedge clk);
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en); end
        n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", host_ack); end
        n_checks++; if (host_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", host_busy); end
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", core_stall); end
`ifdef ARB_STATS_EN
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_idle_load();
        logic [7:0] a, d;
        mem[8'h20] = 8'h5A; ref_mem[8'h20] = 8'h5A;
        core_req = 1; core_we = 0; core_addr = 8'h20;
        #1;
        n_checks++; if (core_rdata !== 8'h5A) begin n_fail++; $display("FAIL idle_load got=%h exp=5a", core_rdata); end
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL idle_load_stall got=%b exp=0", core_stall); end
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom); d = 8'($urandom);
            core_req = 1; core_we = 1; core_addr = a; core_wdata = d;
            @(negedge clk);
            n_checks++; if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL core_store_en got=%b exp=1", mem_wr_en); end
            next_cycle();
            ref_mem[a] = d;
            core_we = 0;
            @(negedge clk);
            n_checks++; if (core_rdata !== ref_mem[a]) begin n_fail++; $display("FAIL core_load addr=%h got=%h exp=%h", a, core_rdata, ref_mem[a]); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_host_write_wrap();
        logic [7:0] exp_a;
        logic [7:0] data [4];
        data[0] = 8'hA1; data[1] = 8'hA2; data[2] = 8'hA3; data[3] = 8'hA4;
        idle_inputs();
        host_req = 1; host_we = 1; host_addr = 8'hFE; host_len = 4'd3;
        @(negedge clk);
        n_checks++; if (host_busy !== 1'b0) begin n_fail++; $display("FAIL wr_cycle0_busy got=%b exp=0", host_busy); end
        next_cycle();
        host_req = 0;
        for (int i = 0; i < 4; i++) begin
            exp_a = 8'hFE + 8'(i);
            host_wdata = data[i];
            @(negedge clk);
            n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack beat=%0d got=%b exp=1", i, host_ack); end
            n_checks++; if (mem_addr !== exp_a || mem_wr_en !== 1'b1) begin
                n_fail++; $display("FAIL wr_beat beat=%0d addr=%h we=%b exp_addr=%h exp_we=1", i, mem_addr, mem_wr_en, exp_a);
            end
            next_cycle();
            ref_mem[exp_a] = data[i];
        end
        @(negedge clk);
        n_checks++; if (host_busy !== 1'b0 || host_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_cycle5 busy=%b ack=%b exp=0/0", host_busy, host_ack);
        end
        n_checks++; if (mem[8'hFE] !== 8'hA1 || mem[8'hFF] !== 8'hA2 || mem[8'h00] !== 8'hA3 || mem[8'h01] !== 8'hA4) begin
            n_fail++; $display("FAIL wr_wrap mem=%h %h %h %h exp=a1 a2 a3 a4", mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic exp_s;
        apply_reset();
        for (int cyc = 0; cyc <= 8; cyc++) begin
            host_req = (cyc < 4); host_we = 0; host_addr = 8'h40; host_len = 4'd3;
            core_req = 1; core_we = 0; core_addr = 8'h20;
            @(negedge clk);
            exp_s = (cyc >= 4 && cyc <= 7);
            n_checks++; if (core_stall !== exp_s || host_busy !== exp_s) begin
                n_fail++; $display("FAIL contention cyc=%0d stall=%b busy=%b exp=%b", cyc, core_stall, host_busy, exp_s);
            end
            next_cycle();
        end
        idle_inputs();
`ifdef ARB_STATS_EN
        n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=4", stall_cnt); end
        rst_n = 0;
        #1;
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_cnt_reset got=%0d exp=0", stall_cnt); end
        @(negedge clk);
        rst_n = 1;
        next_cycle();
`endif
    endtask

    task automatic test_single_read();
        int acks = 0;
        int writes = 0;
        logic [7:0] rd = 8'h00;
        mem[8'h33] = 8'hC3; ref_mem[8'h33] = 8'hC3;
        idle_inputs();
        host_req = 1; host_we = 0; host_addr = 8'h33; host_len = 4'd0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (host_ack === 1'b1) begin acks++; rd = host_rdata; end
            if (mem_wr_en === 1'b1) writes++;
            next_cycle();
            host_req = 0;
        end
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL single_read_acks got=%0d exp=1", acks); end
        n_checks++; if (rd !== 8'hC3) begin n_fail++; $display("FAIL single_read_data got=%h exp=c3", rd); end
        n_checks++; if (writes != 0) begin n_fail++; $display("FAIL single_read_writes got=%0d exp=0", writes); end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] d [8];
        int bad = 0;
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom) | 8'h01;
        for (int i = 0; i < 8; i++) begin mem[8'h10 + 8'(i)] = 8'h00; ref_mem[8'h10 + 8'(i)] = 8'h00; end
        idle_inputs();
        host_req = 1; host_we = 1; host_addr = 8'h10; host_len = 4'd7;
        next_cycle();
        host_req = 0;
        for (int i = 0; i < 3; i++) begin
            host_wdata = d[i];
            next_cycle();
            ref_mem[8'h10 + 8'(i)] = d[i];
        end
        host_wdata = d[3];
        rst_n = 0;
        #1;
        n_checks++; if (mem_wr_en !== 1'b0 || host_ack !== 1'b0 || host_busy !== 1'b0) begin
            n_fail++; $display("FAIL abort we=%b ack=%b busy=%b exp=0/0/0", mem_wr_en, host_ack, host_busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        next_cycle();
        core_req = 1; core_we = 0; core_addr = 8'h10;
        @(negedge clk);
        n_checks++; if (host_busy !== 1'b0 || core_stall !== 1'b0 || core_rdata !== d[0]) begin
            n_fail++; $display("FAIL after_abort busy=%b stall=%b rdata=%h exp=0/0/%h", host_busy, core_stall, core_rdata, d[0]);
        end
        for (int i = 0; i < 8; i++) if (mem[8'h10 + 8'(i)] !== ref_mem[8'h10 + 8'(i)]) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_mem bad_bytes=%0d exp=0", bad); end
        next_cycle();
        idle_inputs();
    endtask

    // Host is granted on the first waiting cycle with no core request, or after MAX_WAIT core-served cycles.
    task automatic test_random_bursts();
        logic       we;
        logic [7:0] base, ea, wd;
        logic [3:0] len;
        logic       creq [MAX_WAIT];
        int         grant_at;
        int         bad = 0;
        for (int b = 0; b < 24; b++) begin
            we = 1'($urandom); base = 8'($urandom); len = 4'($urandom);
            for (int c = 0; c < MAX_WAIT; c++) creq[c] = ($urandom_range(0, 3) != 0);
            grant_at = MAX_WAIT - 1;
            for (int c = MAX_WAIT - 1; c >= 0; c--) if (!creq[c]) grant_at = c;
            for (int c = 0; c <= grant_at; c++) begin
                host_req = 1; host_we = we; host_addr = base; host_len = len;
                core_req = creq[c]; core_we = 0; core_addr = 8'($urandom);
                @(negedge clk);
                n_checks++; if (host_busy !== 1'b0 || core_stall !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_wait b=%0d c=%0d busy=%b stall=%b exp=0/0", b, c, host_busy, core_stall);
                end
                if (core_req) begin
                    n_checks++; if (core_rdata !== ref_mem[core_addr]) begin
                        n_fail++; $display("FAIL rnd_core_load addr=%h got=%h exp=%h", core_addr, core_rdata, ref_mem[core_addr]);
                    end
                end
                next_cycle();
            end
            for (int i = 0; i <= int'(len); i++) begin
                ea = base + 8'(i); wd = 8'($urandom);
                host_req = 1'($urandom); host_we = 1'($urandom); host_addr = 8'($urandom); host_len = 4'($urandom);
                host_wdata = wd;
                core_req = 1'($urandom); core_addr = 8'($urandom);
                @(negedge clk);
                n_checks++; if (host_ack !== 1'b1 || core_stall !== core_req || mem_addr !== ea || mem_wr_en !== we) begin
                    n_fail++; $display("FAIL rnd_beat b=%0d i=%0d ack=%b stall=%b addr=%h we=%b exp=1/%b/%h/%b",
                                       b, i, host_ack, core_stall, mem_addr, mem_wr_en, core_req, ea, we);
                end
                if (!we) begin
                    n_checks++; if (host_rdata !== ref_mem[ea]) begin
                        n_fail++; $display("FAIL rnd_host_read addr=%h got=%h exp=%h", ea, host_rdata, ref_mem[ea]);
                    end
                end
                next_cycle();
                if (we) ref_mem[ea] = wd;
            end
            host_req = 0; core_req = 1; core_we = 0; core_addr = 8'($urandom);
            @(negedge clk);
            n_checks++; if (host_busy !== 1'b0 || core_stall !== 1'b0 || core_rdata !== ref_mem[core_addr]) begin
                n_fail++; $display("FAIL rnd_core_slot b=%0d busy=%b stall=%b rdata=%h exp=0/0/%h",
                                   b, host_busy, core_stall, core_rdata, ref_mem[core_addr]);
            end
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rnd_final_mem bad_bytes=%0d exp=0", bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        idle_inputs();
        rst_n = 1;
        #2;
        test_reset();
        test_idle_load();
        test_host_write_wrap();
        test_contention();
        test_single_read();
        test_reset_mid_burst();
        test_random_bursts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
